// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg
//   Shared definitions for the sequential ALU: opcode encoding, controller
//   state encoding, the mode selector of the iterative unit, and two small
//   helpers that classify an opcode.
package seq_alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_SLL = 3'b010,
        OP_SRA = 3'b011,
        OP_AND = 3'b100,
        OP_OR  = 3'b101,
        OP_XOR = 3'b110,
        OP_MUL = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        IT_SLL = 2'd0,
        IT_SRA = 2'd1,
        IT_MUL = 2'd2
    } iter_mode_e;

    // Shifts by zero finish in one cycle like the logic ops, so only
    // non-zero shifts and MUL go through the iterative unit.
    function automatic logic is_iter_op(alu_op_e op, logic amt_zero);
        return (op == OP_MUL) || (((op == OP_SLL) || (op == OP_SRA)) && !amt_zero);
    endfunction

    function automatic iter_mode_e iter_mode_of(alu_op_e op);
        case (op)
            OP_MUL:  return IT_MUL;
            OP_SRA:  return IT_SRA;
            default: return IT_SLL;
        endcase
    endfunction

endpackage

// File: rtl/seq_alu_if.sv
// seq_alu_if
//   Request/result bundle of the sequential ALU.
//   master : drives input_start, input_ALUOp, input_A, input_B;
//            observes output_ALU, the four flags, output_busy, output_done.
//   slave  : the ALU side of the same signals.
interface seq_alu_if #(
    parameter int WIDTH = 16
) ();
    logic             input_start;
    logic [2:0]       input_ALUOp;
    logic [WIDTH-1:0] input_A;
    logic [WIDTH-1:0] input_B;
    logic [WIDTH-1:0] output_ALU;
    logic             output_Zero;
    logic             output_negative;
    logic             output_carry;
    logic             output_overflow;
    logic             output_busy;
    logic             output_done;

    modport master (
        output input_start, input_ALUOp, input_A, input_B,
        input  output_ALU, output_Zero, output_negative, output_carry,
               output_overflow, output_busy, output_done
    );

    modport slave (
        input  input_start, input_ALUOp, input_A, input_B,
        output output_ALU, output_Zero, output_negative, output_carry,
               output_overflow, output_busy, output_done
    );
endinterface

// File: rtl/seq_alu_iter_unit.sv
// seq_alu_iter_unit
//   Bit-serial datapath for SLL, SRA and unsigned shift-add MUL.
//   Ports:
//     clk, rst        clock, asynchronous active-high reset
//     load            accept a new operation from a_in/b_in/mode_in and
//                     perform its first step on the same edge
//     run             perform one more step on the held operation
//     mode_in         operation kind at load
//     a_in, b_in      operands at load (b_in[SHW-1:0] is the shift amount)
//     result          value after the current step (combinational)
//     ovf             MUL only: high half of the product after this step is non-zero
//     finish          the current step is the last one
//   The first step happens on the load edge itself, so an n-step operation
//   is complete after n edges counting the load edge.
module seq_alu_iter_unit
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             run,
    input  iter_mode_e       mode_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic             finish
);

    // Holds both a full shift amount (up to 2**SHW-1) and WIDTH.
    localparam int CW = SHW + 1;

    iter_mode_e         mode_q, mode_s;
    logic [WIDTH-1:0]   sh_q, sh_s, sh_n;
    logic [2*WIDTH-1:0] acc_q, acc_s, acc_n;
    logic [2*WIDTH-1:0] mcand_q, mcand_s, mcand_n;
    logic [WIDTH-1:0]   mplier_q, mplier_s, mplier_n;
    logic [CW-1:0]      cnt_q, cnt_s, cnt_n;

    // Source of the current step: fresh operands on load, held state otherwise.
    always_comb begin
        if (load) begin
            mode_s   = mode_in;
            sh_s     = a_in;
            acc_s    = '0;
            mcand_s  = {{WIDTH{1'b0}}, a_in};
            mplier_s = b_in;
            cnt_s    = (mode_in == IT_MUL) ? CW'(WIDTH) : {1'b0, b_in[SHW-1:0]};
        end else begin
            mode_s   = mode_q;
            sh_s     = sh_q;
            acc_s    = acc_q;
            mcand_s  = mcand_q;
            mplier_s = mplier_q;
            cnt_s    = cnt_q;
        end
    end

    always_comb begin
        sh_n     = (mode_s == IT_SRA) ? {sh_s[WIDTH-1], sh_s[WIDTH-1:1]}
                                      : {sh_s[WIDTH-2:0], 1'b0};
        acc_n    = mplier_s[0] ? (acc_s + mcand_s) : acc_s;
        mcand_n  = {mcand_s[2*WIDTH-2:0], 1'b0};
        mplier_n = {1'b0, mplier_s[WIDTH-1:1]};
        cnt_n    = cnt_s - CW'(1);
    end

    assign finish = (cnt_n == '0);
    assign result = (mode_s == IT_MUL) ? acc_n[WIDTH-1:0] : sh_n;
    assign ovf    = (mode_s == IT_MUL) && (acc_n[2*WIDTH-1:WIDTH] != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q   <= IT_SLL;
            sh_q     <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else if (load || run) begin
            mode_q   <= mode_s;
            sh_q     <= sh_n;
            acc_q    <= acc_n;
            mcand_q  <= mcand_n;
            mplier_q <= mplier_n;
            cnt_q    <= cnt_n;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// seq_alu
//   Sequential ALU: ADD/SUB/AND/OR/XOR and zero-amount shifts complete in
//   one cycle; non-zero shifts go one bit per cycle and MUL one multiplier
//   bit per cycle through seq_alu_iter_unit. Result and flags are
//   registered on the edge entering DONE and held until the next completion.
//   Ports:
//     input_CLK    clock
//     input_Reset  asynchronous active-high reset
//     bus          seq_alu_if.slave (start/op/operands in, result/flags/busy/done out)
//
//   state   | meaning
//   IDLE    | waiting for input_start
//   EXEC    | iterative shift or multiply in progress
//   DONE    | result valid, output_done high for this cycle
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic    input_CLK,
    input  logic    input_Reset,
    seq_alu_if.slave bus
);

    state_e           state_q, state_d;
    alu_op_e          op_in;
    logic             amt_zero;

    logic             it_load, it_run, it_ovf, it_finish;
    logic [WIDTH-1:0] it_result;

    logic [WIDTH-1:0] sc_res;
    logic             sc_carry, sc_ovf;
    logic [WIDTH:0]   add_ext, sub_ext;

    logic             res_we;
    logic [WIDTH-1:0] res_d;
    logic             carry_d, ovf_d;

    logic [WIDTH-1:0] alu_q;
    logic             zero_q, neg_q, carry_q, ovf_q;

    assign op_in    = alu_op_e'(bus.input_ALUOp);
    assign amt_zero = (bus.input_B[SHW-1:0] == '0);

    seq_alu_iter_unit #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_iter (
        .clk     (input_CLK),
        .rst     (input_Reset),
        .load    (it_load),
        .run     (it_run),
        .mode_in (iter_mode_of(op_in)),
        .a_in    (bus.input_A),
        .b_in    (bus.input_B),
        .result  (it_result),
        .ovf     (it_ovf),
        .finish  (it_finish)
    );

    // Single-cycle ops, evaluated straight from the bus at the accept edge.
    // sub_ext[WIDTH] is the borrow of the unsigned subtraction.
    assign add_ext = {1'b0, bus.input_A} + {1'b0, bus.input_B};
    assign sub_ext = {1'b0, bus.input_A} - {1'b0, bus.input_B};

    always_comb begin
        sc_res   = bus.input_A;
        sc_carry = 1'b0;
        sc_ovf   = 1'b0;
        case (op_in)
            OP_ADD: begin
                sc_res   = add_ext[WIDTH-1:0];
                sc_carry = add_ext[WIDTH];
                sc_ovf   = (bus.input_A[WIDTH-1] == bus.input_B[WIDTH-1]) &&
                           (add_ext[WIDTH-1] != bus.input_A[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res   = sub_ext[WIDTH-1:0];
                sc_carry = sub_ext[WIDTH];
                sc_ovf   = (bus.input_A[WIDTH-1] != bus.input_B[WIDTH-1]) &&
                           (sub_ext[WIDTH-1] != bus.input_A[WIDTH-1]);
            end
            OP_AND:  sc_res = bus.input_A & bus.input_B;
            OP_OR:   sc_res = bus.input_A | bus.input_B;
            OP_XOR:  sc_res = bus.input_A ^ bus.input_B;
            default: sc_res = bus.input_A;
        endcase
    end

    always_ff @(posedge input_CLK or posedge input_Reset) begin
        if (input_Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        it_load = 1'b0;
        it_run  = 1'b0;
        res_we  = 1'b0;
        res_d   = sc_res;
        carry_d = sc_carry;
        ovf_d   = sc_ovf;
        case (state_q)
            ST_IDLE: begin
                if (bus.input_start) begin
                    if (is_iter_op(op_in, amt_zero)) begin
                        it_load = 1'b1;
                        // A one-bit shift is finished by its load step.
                        if (it_finish) begin
                            state_d = ST_DONE;
                            res_we  = 1'b1;
                            res_d   = it_result;
                            carry_d = 1'b0;
                            ovf_d   = it_ovf;
                        end else begin
                            state_d = ST_EXEC;
                        end
                    end else begin
                        state_d = ST_DONE;
                        res_we  = 1'b1;
                    end
                end
            end
            ST_EXEC: begin
                it_run = 1'b1;
                if (it_finish) begin
                    state_d = ST_DONE;
                    res_we  = 1'b1;
                    res_d   = it_result;
                    carry_d = 1'b0;
                    ovf_d   = it_ovf;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge input_CLK or posedge input_Reset) begin
        if (input_Reset) begin
            alu_q   <= '0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (res_we) begin
            alu_q   <= res_d;
            zero_q  <= (res_d == '0);
            neg_q   <= res_d[WIDTH-1];
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.output_ALU      = alu_q;
    assign bus.output_Zero     = zero_q;
    assign bus.output_negative = neg_q;
    assign bus.output_carry    = carry_q;
    assign bus.output_overflow = ovf_q;
    assign bus.output_busy     = (state_q != ST_IDLE);
    assign bus.output_done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu
//   Directed vectors with hand-computed results for seq_alu at WIDTH=16.
//   Inputs change and outputs are sampled on the falling clock edge.
module tb_seq_alu;
    import seq_alu_pkg::*;

    localparam int WIDTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    seq_alu_if #(.WIDTH(WIDTH)) bus ();

    seq_alu #(.WIDTH(WIDTH)) dut (
        .input_CLK   (clk),
        .input_Reset (rst),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Launch one op and follow it to its done pulse. poke_cyc > 0 drives a
    // competing ADD request with different operands during that cycle.
    // rel_rst pulses reset just before the accept edge, so the accept edge is
    // the first edge after reset release.
    task automatic run_op(input string tag, input alu_op_e op,
                          input logic [15:0] a, input logic [15:0] b,
                          input int exp_cyc, input logic [15:0] exp_res,
                          input logic exp_z, input logic exp_n,
                          input logic exp_c, input logic exp_v,
                          input int poke_cyc, input bit rel_rst);
        int  cyc;
        bit  busy_ok;
        @(negedge clk);
        if (rel_rst) rst = 1'b1;
        bus.input_ALUOp = op;
        bus.input_A     = a;
        bus.input_B     = b;
        bus.input_start = 1'b1;
        if (rel_rst) begin
            #1;
            rst = 1'b0;
        end
        chk($sformatf("%s.idle_busy", tag), 64'(bus.output_busy), 64'd0);
        @(negedge clk);
        bus.input_start = 1'b0;
        cyc     = 1;
        busy_ok = 1'b1;
        while (!bus.output_done && cyc < 40) begin
            if (bus.output_busy !== 1'b1) busy_ok = 1'b0;
            if (poke_cyc > 0 && cyc == poke_cyc) begin
                bus.input_ALUOp = OP_ADD;
                bus.input_A     = 16'h1111;
                bus.input_B     = 16'h2222;
                bus.input_start = 1'b1;
            end else begin
                bus.input_start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        bus.input_start = 1'b0;
        if (bus.output_busy !== 1'b1) busy_ok = 1'b0;
        chk($sformatf("%s.done_cycle", tag), 64'(cyc), 64'(exp_cyc));
        chk($sformatf("%s.busy", tag), 64'(busy_ok), 64'd1);
        chk($sformatf("%s.alu", tag), 64'(bus.output_ALU), 64'(exp_res));
        chk($sformatf("%s.zero", tag), 64'(bus.output_Zero), 64'(exp_z));
        chk($sformatf("%s.neg", tag), 64'(bus.output_negative), 64'(exp_n));
        chk($sformatf("%s.carry", tag), 64'(bus.output_carry), 64'(exp_c));
        chk($sformatf("%s.ovf", tag), 64'(bus.output_overflow), 64'(exp_v));
        @(negedge clk);
        chk($sformatf("%s.done_pulse", tag), 64'(bus.output_done), 64'd0);
        chk($sformatf("%s.hold", tag), 64'(bus.output_ALU), 64'(exp_res));
    endtask

    initial begin
        int dones;
        bus.input_start = 1'b0;
        bus.input_ALUOp = 3'b000;
        bus.input_A     = '0;
        bus.input_B     = '0;

        repeat (3) @(negedge clk);
        chk("rst.alu",  64'(bus.output_ALU), 64'd0);
        chk("rst.flags", 64'({bus.output_Zero, bus.output_negative,
                              bus.output_carry, bus.output_overflow}), 64'd0);
        chk("rst.busy", 64'(bus.output_busy), 64'd0);
        chk("rst.done", 64'(bus.output_done), 64'd0);
        rst = 1'b0;

        //      tag        op      A         B        cyc  result    Z     N     C     V     poke rr
        run_op("add_ovf",  OP_ADD, 16'h7FFF, 16'h0001, 1, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b0);
        run_op("add_wrap", OP_ADD, 16'hFFFF, 16'h0001, 1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        run_op("add_neg2", OP_ADD, 16'h8000, 16'h8000, 1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0);
        run_op("sub_eq",   OP_SUB, 16'h1234, 16'h1234, 1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        run_op("sub_brw",  OP_SUB, 16'h0000, 16'h0001, 1, 16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        run_op("sub_ovf",  OP_SUB, 16'h8000, 16'h0001, 1, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        run_op("and",      OP_AND, 16'hF0F0, 16'h0FF0, 1, 16'h00F0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        run_op("or",       OP_OR,  16'h1200, 16'h0034, 1, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        run_op("xor",      OP_XOR, 16'hFFFF, 16'hFFFF, 1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        run_op("sll15",    OP_SLL, 16'h0001, 16'd15,   15, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        run_op("sll1",     OP_SLL, 16'h0003, 16'd1,    1, 16'h0006, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        run_op("sll8",     OP_SLL, 16'hFFFF, 16'd8,    8, 16'hFF00, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        run_op("sra4",     OP_SRA, 16'h8000, 16'd4,    4, 16'hF800, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        run_op("sra1",     OP_SRA, 16'h8001, 16'd1,    1, 16'hC000, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        run_op("sra0",     OP_SRA, 16'h1234, 16'h0010, 1, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        run_op("mul_ff",   OP_MUL, 16'h00FF, 16'h0101, 16, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        run_op("mul_hi",   OP_MUL, 16'h0100, 16'h0100, 16, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        run_op("mul_max",  OP_MUL, 16'hFFFF, 16'hFFFF, 16, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        run_op("mul_poke", OP_MUL, 16'h0012, 16'h0034, 16, 16'h03A8, 1'b0, 1'b0, 1'b0, 1'b0, 5, 1'b0);

        // Abort a MUL at cycle 8: outputs clear at once and no done follows.
        @(negedge clk);
        bus.input_ALUOp = OP_MUL;
        bus.input_A     = 16'h1234;
        bus.input_B     = 16'h0002;
        bus.input_start = 1'b1;
        @(negedge clk);
        bus.input_start = 1'b0;
        repeat (7) @(negedge clk);
        chk("abort.busy_before", 64'(bus.output_busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("abort.alu",  64'(bus.output_ALU), 64'd0);
        chk("abort.flags", 64'({bus.output_Zero, bus.output_negative,
                                bus.output_carry, bus.output_overflow}), 64'd0);
        chk("abort.busy", 64'(bus.output_busy), 64'd0);
        chk("abort.done", 64'(bus.output_done), 64'd0);
        @(negedge clk);
        rst   = 1'b0;
        dones = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.output_done) dones++;
        end
        chk("abort.no_done", 64'(dones), 64'd0);
        run_op("mul_after", OP_MUL, 16'h0123, 16'h0045, 16, 16'h4E6F, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);

        // Start held high across reset release is taken on the first edge.
        run_op("rel_start", OP_ADD, 16'h0001, 16'h0002, 1, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
